// File: rtl/async_fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer controllers: depth and
// Gray/binary conversion over a fixed maximum width with masking.
package async_fifo_pkg;

  localparam int MAX_W = 16;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b, input int w);
    logic [MAX_W-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Bits above the active width are masked to zero, so the prefix XOR
  // starting at MAX_W-1 is correct for any width.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int w);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    gm = g & width_mask(w);
    b = '0;
    b[MAX_W-1] = gm[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_wptr_ctrl_gray2bin_conv.sv
// Combinational Gray-to-binary converter; shared by the write- and
// read-side pointer controllers for the synchronised remote pointer.
module gray2bin_conv
  import async_fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each bit is an independent reduction, avoiding a ripple chain.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign bin[gi] = ^gray[W-1:gi];
  end

endmodule

// File: rtl/async_fifo_wptr_ctrl.sv
// Write-domain pointer/flag controller for the dual-clock FIFO.
// Optional registered level output: define ASYNC_FIFO_WLEVEL_EN.
module async_fifo_wptr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int AFULL_RST = 2**ADDR_W - 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              winc,
  input  logic [ADDR_W:0]   wq2_rptr,
  input  logic [ADDR_W:0]   wafull_thresh,
  input  logic              wovf_clr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic              wafull,
  output logic              wovf
`ifdef ASYNC_FIFO_WLEVEL_EN
  ,
  output logic [ADDR_W:0]   wlevel
`endif
);

  localparam int PW = ADDR_W + 1;

  // AFULL_RST is the integrator's default threshold; keep it meaningful.
  if (ADDR_W < 2 || ADDR_W > 12) begin : g_bad_addr_w
    $error("async_fifo_wptr_ctrl: ADDR_W must be 2..12");
  end
  if (AFULL_RST < 0 || AFULL_RST > depth_of(ADDR_W) + 1) begin : g_bad_afull_rst
    $error("async_fifo_wptr_ctrl: AFULL_RST out of range");
  end

  logic [ADDR_W:0] bptr_reg;
  logic [ADDR_W:0] wptr_reg;
  logic            wfull_reg;
  logic            wafull_reg;
  logic            wovf_reg;

  logic [ADDR_W:0] bnext;
  logic [ADDR_W:0] gnext;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] lvl_next;
  logic [ADDR_W:0] full_cmp;
  logic            wfull_next;
  logic            wafull_next;
  logic            wovf_next;

  gray2bin_conv #(.W(PW)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  assign wen      = winc & ~wfull_reg;
  assign bnext    = bptr_reg + PW'(wen);
  assign gnext    = PW'(bin2gray(MAX_W'(bnext), PW));
  assign lvl_next = bnext - rbin;

  // Full when the next write pointer is one lap ahead of the read pointer.
  assign full_cmp    = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
  assign wfull_next  = (gnext == full_cmp);
  assign wafull_next = (lvl_next >= wafull_thresh);
  assign wovf_next   = (wovf_reg & ~wovf_clr) | (winc & wfull_reg);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      bptr_reg   <= '0;
      wptr_reg   <= '0;
      wfull_reg  <= 1'b0;
      wafull_reg <= 1'b0;
      wovf_reg   <= 1'b0;
    end else begin
      bptr_reg   <= bnext;
      wptr_reg   <= gnext;
      wfull_reg  <= wfull_next;
      wafull_reg <= wafull_next;
      wovf_reg   <= wovf_next;
    end
  end

`ifdef ASYNC_FIFO_WLEVEL_EN
  logic [ADDR_W:0] wlevel_reg;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_reg <= '0;
    end else begin
      wlevel_reg <= lvl_next;
    end
  end

  assign wlevel = wlevel_reg;
`endif

  assign waddr  = bptr_reg[ADDR_W-1:0];
  assign wptr   = wptr_reg;
  assign wfull  = wfull_reg;
  assign wafull = wafull_reg;
  assign wovf   = wovf_reg;

endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Directed testbench for async_fifo_wptr_ctrl at ADDR_W=4 (DEPTH=16).
module tb_async_fifo_wptr_ctrl;

  localparam int AW = 4;
  localparam int PW = AW + 1;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] wafull_thresh;
  logic          wovf_clr;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr;
  logic          wfull;
  logic          wafull;
  logic          wovf;
`ifdef ASYNC_FIFO_WLEVEL_EN
  logic [PW-1:0] wlevel;
`endif

  int n_checks = 0;
  int n_errors = 0;

  async_fifo_wptr_ctrl #(.ADDR_W(AW)) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .winc          (winc),
    .wq2_rptr      (wq2_rptr),
    .wafull_thresh (wafull_thresh),
    .wovf_clr      (wovf_clr),
    .wen           (wen),
    .waddr         (waddr),
    .wptr          (wptr),
    .wfull         (wfull),
    .wafull        (wafull),
    .wovf          (wovf)
`ifdef ASYNC_FIFO_WLEVEL_EN
    ,
    .wlevel        (wlevel)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] bb;
    bb = PW'(b);
    return bb ^ (bb >> 1);
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    #1;
    tick();
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n        = 1'b0;
    winc          = 1'b0;
    wq2_rptr      = '0;
    wafull_thresh = 5'd14;
    wovf_clr      = 1'b0;

    #3;
    check("rst_wptr", wptr, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wfull", wfull, 0);
    check("rst_wafull", wafull, 0);
    check("rst_wovf", wovf, 0);
    tick();
    tick();
    wrst_n = 1'b1;

    // Fill to full with the read pointer parked at 0
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1;
      #1;
      check("fill_wen", wen, 1);
      check("fill_waddr", waddr, i);
      tick();
      check("fill_wptr", wptr, gray(i + 1));
      check("fill_wfull", wfull, (i == 15));
      check("fill_wafull", wafull, (i + 1 >= 14));
      $display("fill write %0d addr=%0d wptr=%b wfull=%0b", i, i, wptr, wfull);
    end
    check("fill_wptr16", wptr, 5'b11000);

    // Overflow attempts while full
    for (int i = 0; i < 3; i++) begin
      winc = 1'b1;
      #1;
      check("ovf_wen", wen, 0);
      tick();
      check("ovf_wptr", wptr, 5'b11000);
      check("ovf_waddr", waddr, 0);
      check("ovf_wovf", wovf, 1);
      $display("overflow attempt %0d wovf=%0b", i, wovf);
    end
    winc = 1'b0;
    tick();
    check("ovf_hold", wovf, 1);
    wovf_clr = 1'b1;
    tick();
    check("ovf_clr", wovf, 0);
    winc = 1'b1;
    tick();
    check("ovf_set_wins", wovf, 1);
    tick();
    check("ovf_set_wins_held", wovf, 1);
    winc     = 1'b0;
    wovf_clr = 1'b0;

    // Asynchronous reset clears a set overflow flag without a clock
    wafull_thresh = 5'd12;
    #2;
    wrst_n = 1'b0;
    #1;
    check("arst_wovf", wovf, 0);
    check("arst_wfull", wfull, 0);
    check("arst_wptr", wptr, 0);
    tick();
    wrst_n = 1'b1;

    // Almost-full threshold 12
    for (int i = 0; i < 12; i++) begin
      winc = 1'b1;
      tick();
      check("afull_lvl", wafull, (i + 1 >= 12));
      $display("afull write %0d wafull=%0b", i, wafull);
    end
    winc     = 1'b0;
    wq2_rptr = gray(2);
    tick();
    check("afull_after_read", wafull, 0);
    check("afull_wptr", wptr, gray(12));
    check("afull_wfull", wfull, 0);

    // Streaming with the read pointer two writes behind, wrapping the pointer
    wafull_thresh = 5'd14;
    wq2_rptr      = '0;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      wq2_rptr = gray((k >= 2) ? (k - 2) : 0);
      winc     = 1'b1;
      #1;
      check("stream_wen", wen, 1);
      check("stream_waddr", waddr, k % 16);
      tick();
      check("stream_wptr", wptr, gray((k + 1) % 32));
      check("stream_wfull", wfull, 0);
      check("stream_wafull", wafull, 0);
      $display("stream write %0d addr=%0d wptr=%b", k, k % 16, wptr);
    end
    winc = 1'b0;

    // Threshold 0 forces almost-full from the first edge after reset
    wq2_rptr      = '0;
    wafull_thresh = 5'd0;
    wrst_n        = 1'b0;
    #1;
    check("thr0_in_reset", wafull, 0);
    tick();
    wrst_n = 1'b1;
    tick();
    check("thr0_first_edge", wafull, 1);

    // Threshold 17 is unreachable, even at full
    wafull_thresh = 5'd17;
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1;
      tick();
      check("thr17_wafull", wafull, 0);
    end
    check("thr17_wfull", wfull, 1);
    winc = 1'b0;

    // Asynchronous reset mid-burst at level 9
    wafull_thresh = 5'd9;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      winc = 1'b1;
      tick();
    end
    check("mid_wafull_pre", wafull, 1);
    check("mid_wptr_pre", wptr, gray(9));
`ifdef ASYNC_FIFO_WLEVEL_EN
    check("mid_wlevel_pre", wlevel, 9);
`endif
    #2;
    wrst_n = 1'b0;
    #1;
    check("mid_rst_wptr", wptr, 0);
    check("mid_rst_waddr", waddr, 0);
    check("mid_rst_wfull", wfull, 0);
    check("mid_rst_wafull", wafull, 0);
    check("mid_rst_wovf", wovf, 0);
`ifdef ASYNC_FIFO_WLEVEL_EN
    check("mid_rst_wlevel", wlevel, 0);
`endif
    winc = 1'b0;
    tick();
    wrst_n = 1'b1;
    tick();
    check("post_rst_wptr", wptr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
